adder_driver: RTL and testbench

ADDER_DRIVER -- requirements
Module: adder_driver

---
 rtl/adder_driver.sv | 139 +++++++++++++
 tb/tb_adder_driver.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_driver.sv
// Adder driver: buffers operand pairs in a small FIFO, presents each pair to an
// external combinational adder, waits SETTLE cycles, then captures and offers the sum.
module adder_driver #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] drv_a,
  output logic [3:0] drv_b,
  input  logic [4:0] sum_c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_sum,
  output logic [7:0] result_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    drv_a_q, drv_a_d;
  logic [3:0]    drv_b_q, drv_b_d;
  logic [4:0]    out_sum_q, out_sum_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    result_count_q, result_count_d;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // in_ready is forced low during reset so no pair can slip in while state is clearing
  assign in_ready     = rst_n && (count_q != CW'(DEPTH));
  assign push         = in_valid && in_ready;
  assign head         = mem[rd_ptr_q];
  assign drv_a        = drv_a_q;
  assign drv_b        = drv_b_q;
  assign out_sum      = out_sum_q;
  assign out_valid    = out_valid_q;
  assign result_count = result_count_q;

  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    drv_a_d        = drv_a_q;
    drv_b_d        = drv_b_q;
    out_sum_d      = out_sum_q;
    out_valid_d    = out_valid_q;
    result_count_d = result_count_q;
    pop            = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          drv_a_d  = head[7:4];
          drv_b_d  = head[3:0];
          settle_d = SETTLE_LOAD;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q != '0) begin
          settle_d = settle_q - SW'(1);
        end else begin
          out_sum_d   = sum_c;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d    = 1'b0;
          result_count_d = result_count_q + 8'd1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage needs no reset: the cleared count makes stale entries unreachable
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      settle_q       <= '0;
      drv_a_q        <= '0;
      drv_b_q        <= '0;
      out_sum_q      <= '0;
      out_valid_q    <= 1'b0;
      result_count_q <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      settle_q       <= settle_d;
      drv_a_q        <= drv_a_d;
      drv_b_q        <= drv_b_d;
      out_sum_q      <= out_sum_d;
      out_valid_q    <= out_valid_d;
      result_count_q <= result_count_d;
    end
  end

endmodule

// File: tb/tb_adder_driver.sv
// Self-checking bench for adder_driver: a scoreboard queue of expected sums plus
// per-scenario tasks; a second instance exercises a longer settle time.
module tb_adder_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_a, in_b, drv_a, drv_b;
  logic [4:0] sum_c, out_sum;
  logic [7:0] result_count;

  logic       in_valid3, in_ready3, out_valid3, out_ready3;
  logic [3:0] in_a3, in_b3, drv_a3, drv_b3;
  logic [4:0] sum_c3, out_sum3;
  logic [7:0] result_count3;

  int         tests = 0;
  int         failed = 0;
  int         pushedCount = 0;
  logic [4:0] expq [$];

  always #5 clk = ~clk;

  // The external combinational adder the driver is connected to
  assign sum_c  = {1'b0, drv_a} + {1'b0, drv_b};
  assign sum_c3 = {1'b0, drv_a3} + {1'b0, drv_b3};

  adder_driver #(.DEPTH(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .drv_a(drv_a), .drv_b(drv_b), .sum_c(sum_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .result_count(result_count)
  );

  adder_driver #(.DEPTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a3), .in_b(in_b3), .drv_a(drv_a3), .drv_b(drv_b3), .sum_c(sum_c3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(out_sum3),
    .result_count(result_count3)
  );

  // Scoreboard: inputs are stable at the falling edge, so handshakes seen here happen at the next rise
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        tests++;
        if (expq.size() == 0) begin
          failed++;
          $display("[TB] FAIL scoreboard_unexpected: got out_sum %0d, expected no result", out_sum);
        end else begin
          logic [4:0] e;
          e = expq.pop_front();
          if (out_sum !== e) begin
            failed++;
            $display("[TB] FAIL scoreboard_sum: got %0d, expected %0d", out_sum, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back({1'b0, in_a} + {1'b0, in_b});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    logic ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      pushedCount++;
    end else begin
      tests++;
      failed++;
      $display("[TB] FAIL push_timeout: got in_ready 0 for 100 cycles, expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_valid) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({drv_a, drv_b, out_sum, out_valid, result_count} !== 22'd0) begin
      failed++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", {drv_a, drv_b, out_sum, out_valid, result_count});
    end
    tests++;
    if (in_ready !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready);
    end
    tests++;
    if ({drv_a3, drv_b3, out_valid3, result_count3} !== 17'd0) begin
      failed++;
      $display("[TB] FAIL reset_outputs3: got %h, expected 0", {drv_a3, drv_b3, out_valid3, result_count3});
    end
    expq.delete();
    pushedCount = 0;
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("[TB] FAIL release_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  // The handshake edge counts as edge 1, so with SETTLE=1 out_valid is up after edge 3
  task automatic test_basic();
    out_ready = 1'b1;
    push_pair(4'd6, 4'd4);
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL basic_early_valid: got %b, expected 0", out_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (drv_a !== 4'd6 || drv_b !== 4'd4 || out_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL basic_drive: got a=%0d b=%0d v=%b, expected a=6 b=4 v=0", drv_a, drv_b, out_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 5'd10) begin
      failed++;
      $display("[TB] FAIL basic_result: got v=%b sum=%0d, expected v=1 sum=10", out_valid, out_sum);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || result_count !== 8'd1) begin
      failed++;
      $display("[TB] FAIL basic_count: got v=%b cnt=%0d, expected v=0 cnt=1", out_valid, result_count);
    end
  endtask

  task automatic test_settle3();
    in_a3 = 4'd6; in_b3 = 4'd4; in_valid3 = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready3 !== 1'b1) begin
      failed++;
      $display("[TB] FAIL settle3_ready: got %b, expected 1", in_ready3);
    end
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (drv_a3 !== 4'd6 || drv_b3 !== 4'd4 || out_valid3 !== 1'b0) begin
        failed++;
        $display("[TB] FAIL settle3_drive%0d: got a=%0d b=%0d v=%b, expected a=6 b=4 v=0", i, drv_a3, drv_b3, out_valid3);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid3 !== 1'b1 || out_sum3 !== 5'd10) begin
      failed++;
      $display("[TB] FAIL settle3_result: got v=%b sum=%0d, expected v=1 sum=10", out_valid3, out_sum3);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid3 !== 1'b0 || result_count3 !== 8'd1) begin
      failed++;
      $display("[TB] FAIL settle3_count: got v=%b cnt=%0d, expected v=0 cnt=1", out_valid3, result_count3);
    end
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    push_pair(4'd15, 4'd15);
    push_pair(4'd0, 4'd0);
    push_pair(4'd15, 4'd1);
    wait_drain();
    tests++;
    if (result_count !== 8'(pushedCount)) begin
      failed++;
      $display("[TB] FAIL extremes_count: got %0d, expected %0d", result_count, 8'(pushedCount));
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [5];
    logic [3:0] bv [5];
    logic [4:0] firstSum;
    av = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    bv = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    firstSum = {1'b0, av[0]} + {1'b0, bv[0]};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pair(av[i], bv[i]);
    tests++;
    if (in_ready !== 1'b0) begin
      failed++;
      $display("[TB] FAIL b2b_full: got in_ready %b, expected 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_sum !== firstSum || drv_a !== av[0] || in_ready !== 1'b0) begin
        failed++;
        $display("[TB] FAIL b2b_hold%0d: got v=%b sum=%0d a=%0d rdy=%b, expected v=1 sum=%0d a=%0d rdy=0",
                 i, out_valid, out_sum, drv_a, in_ready, firstSum, av[0]);
      end
    end
    out_ready = 1'b1;
    wait_drain();
    tests++;
    if (result_count !== 8'(pushedCount)) begin
      failed++;
      $display("[TB] FAIL b2b_count: got %0d, expected %0d", result_count, 8'(pushedCount));
    end
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    out_ready = 1'b0;
    push_pair(4'd7, 4'd1);
    push_pair(4'd2, 4'd2);
    push_pair(4'd3, 4'd3);
    tests++;
    if (out_valid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL midrst_hold: got out_valid %b, expected 1", out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({drv_a, drv_b, out_sum, out_valid, result_count, in_ready} !== 23'd0) begin
      failed++;
      $display("[TB] FAIL midrst_outputs: got %h, expected 0", {drv_a, drv_b, out_sum, out_valid, result_count, in_ready});
    end
    expq.delete();
    pushedCount = 0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      failed++;
      $display("[TB] FAIL midrst_no_valid: got out_valid seen %b, expected 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    wait_drain();
    tests++;
    if (result_count !== 8'd0) begin
      failed++;
      $display("[TB] FAIL wrap_count: got %0d, expected 0", result_count);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_settle3();
    test_extremes();
    test_back_to_back();
    test_reset_mid_op();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
